// File: rtl/snow64_instr_fetch_pkg.sv
// Shared types for the Snow64 instruction fetch stage: widths, slot layout
// and the port bundles exchanged with the decoder and instruction memory.
package PkgSnow64InstrFetch;

    localparam int unsigned WIDTH__INSTR = 32;
    localparam int unsigned WIDTH__ADDR  = 64;

    typedef logic [WIDTH__INSTR-1:0] Instr;
    typedef logic [WIDTH__ADDR-1:0]  Addr;

    typedef struct packed {
        Addr  pc;
        Instr instr;
        logic filled;
    } FetchSlot;

    typedef struct packed {
        logic redirect_valid;
        Addr  redirect_addr;
        logic mem_req_ready;
        logic mem_rsp_valid;
        Instr mem_rsp_data;
        logic out_ready;
    } PortIn_InstrFetch;

    // Field order matches the decoder's input bundle.
    typedef struct packed {
        Instr instr;
        Addr  pc;
    } PortOut_InstrFetch;

    typedef enum logic [1:0] {
        RSP_NONE,
        RSP_FILL,
        RSP_DROP
    } RspAction;

    function automatic Addr align_word(input Addr a);
        return a & ~Addr'(3);
    endfunction

endpackage

// File: rtl/snow64_instr_fetch_if.sv
// Fetch-stage bus: memory request/response channel, decoder output channel
// and redirect input. master = fetch stage, slave = its environment.
interface snow64_instr_fetch_if;
    import PkgSnow64InstrFetch::*;

    logic mem_req_valid;
    logic mem_req_ready;
    Addr  mem_req_addr;
    logic mem_rsp_valid;
    Instr mem_rsp_data;
    logic out_valid;
    logic out_ready;
    Instr out_instr;
    Addr  out_pc;
    logic redirect_valid;
    Addr  redirect_addr;

    modport master (
        output mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
               redirect_valid, redirect_addr
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
               redirect_valid, redirect_addr
    );

endinterface

// File: rtl/snow64_fetch_slot_queue.sv
// In-order circular queue of fetch slots. Slots are allocated at issue,
// filled in allocation order as words return, and popped from the head.
module snow64_fetch_slot_queue
    import PkgSnow64InstrFetch::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             alloc,
    input  Addr              alloc_pc,
    input  logic             fill,
    input  Instr             fill_instr,
    input  logic             pop,
    output FetchSlot         head_slot,
    output logic [CNT_W-1:0] alloc_cnt,
    output logic [CNT_W-1:0] unfilled_cnt
);

    FetchSlot         slots [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] fill_ptr;
    logic [CNT_W-1:0] filled_cnt;

    // Filled slots always form a contiguous run starting at the head.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head_ptr   <= '0;
            tail_ptr   <= '0;
            fill_ptr   <= '0;
            alloc_cnt  <= '0;
            filled_cnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots[i].filled <= 1'b0;
            end
        end else begin
            if (alloc) begin
                slots[tail_ptr].pc     <= alloc_pc;
                slots[tail_ptr].filled <= 1'b0;
                tail_ptr               <= tail_ptr + PTR_W'(1);
            end
            if (fill) begin
                slots[fill_ptr].instr  <= fill_instr;
                slots[fill_ptr].filled <= 1'b1;
                fill_ptr               <= fill_ptr + PTR_W'(1);
            end
            if (pop) begin
                slots[head_ptr].filled <= 1'b0;
                head_ptr               <= head_ptr + PTR_W'(1);
            end
            alloc_cnt  <= alloc_cnt + CNT_W'(alloc) - CNT_W'(pop);
            filled_cnt <= filled_cnt + CNT_W'(fill) - CNT_W'(pop);
        end
    end

    assign head_slot    = slots[head_ptr];
    assign unfilled_cnt = alloc_cnt - filled_cnt;

endmodule

// File: rtl/snow64_instr_fetch.sv
// Snow64 instruction fetch: sequential address generation, bounded request
// issue, in-order word buffering and redirect handling with stale discard.
module snow64_instr_fetch
    import PkgSnow64InstrFetch::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input logic                  clk,
    input logic                  rst_n,
    snow64_instr_fetch_if.master bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    PortIn_InstrFetch  in_p;
    PortOut_InstrFetch out_p;
    FetchSlot          head_slot;
    Addr               fetch_pc;
    logic [CNT_W-1:0]  discard_cnt;
    logic [CNT_W-1:0]  alloc_cnt;
    logic [CNT_W-1:0]  unfilled_cnt;
    logic [SUM_W-1:0]  occupied;
    logic              req_valid;
    logic              req_fire;
    logic              out_valid;
    logic              pop;
    RspAction          rsp_action;

    always_comb begin
        in_p                = '0;
        in_p.redirect_valid = bus.redirect_valid;
        in_p.redirect_addr  = bus.redirect_addr;
        in_p.mem_req_ready  = bus.mem_req_ready;
        in_p.mem_rsp_valid  = bus.mem_rsp_valid;
        in_p.mem_rsp_data   = bus.mem_rsp_data;
        in_p.out_ready      = bus.out_ready;
    end

    // Slots held plus stale words still in flight bound the outstanding requests.
    assign occupied  = SUM_W'(alloc_cnt) + SUM_W'(discard_cnt);
    assign req_valid = rst_n && !in_p.redirect_valid && (occupied < SUM_W'(DEPTH));
    assign req_fire  = req_valid && in_p.mem_req_ready;

    always_comb begin
        rsp_action = RSP_NONE;
        if (in_p.mem_rsp_valid) begin
            if (discard_cnt != '0 || in_p.redirect_valid) begin
                rsp_action = RSP_DROP;
            end else if (unfilled_cnt != '0) begin
                rsp_action = RSP_FILL;
            end
        end
    end

    assign out_valid = rst_n && !in_p.redirect_valid && head_slot.filled;
    assign pop       = out_valid && in_p.out_ready;

    snow64_fetch_slot_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (in_p.redirect_valid),
        .alloc        (req_fire),
        .alloc_pc     (fetch_pc),
        .fill         (rsp_action == RSP_FILL),
        .fill_instr   (in_p.mem_rsp_data),
        .pop          (pop),
        .head_slot    (head_slot),
        .alloc_cnt    (alloc_cnt),
        .unfilled_cnt (unfilled_cnt)
    );

    // A response landing in the redirect cycle is already covered by the
    // unfilled/discard total, so it is subtracted rather than counted stale.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            discard_cnt <= '0;
        end else if (in_p.redirect_valid) begin
            fetch_pc    <= align_word(in_p.redirect_addr);
            discard_cnt <= discard_cnt + unfilled_cnt - CNT_W'(in_p.mem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 64'd4;
            end
            if (rsp_action == RSP_DROP) begin
                discard_cnt <= discard_cnt - CNT_W'(1);
            end
        end
    end

    assign out_p.instr = head_slot.instr;
    assign out_p.pc    = head_slot.pc;

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = fetch_pc;
    assign bus.out_valid     = out_valid;
    assign bus.out_instr     = out_p.instr;
    assign bus.out_pc        = out_p.pc;

endmodule

// File: tb/tb_snow64_instr_fetch.sv
// Bench for snow64_instr_fetch: transaction-level reference model of issued,
// returned and delivered instructions plus directed literal scenarios.
module tb_snow64_instr_fetch;
    import PkgSnow64InstrFetch::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h1000;

    logic clk = 1'b0;
    logic rst_n;

    snow64_instr_fetch_if bus();

    snow64_instr_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] addr; bit stale; int unsigned due; } infl_t;
    typedef struct { logic [63:0] pc; bit delivered; } exp_t;
    typedef struct { logic [63:0] addr; int unsigned cyc; } log_t;

    infl_t inflight[$];
    exp_t  exp_q[$];
    log_t  acc_log[$];
    log_t  pop_log[$];

    logic [63:0] next_addr;
    int unsigned last_due;
    int unsigned cyc = 0;
    int unsigned rel_cyc = 0;
    int unsigned redir_cyc = 0;
    bit          prev_rst = 1'b0;
    logic        last_req_valid;
    logic        busy_out_valid;
    int checks = 0;
    int errors = 0;

    bit          ctl_rst_n;
    int unsigned ready_mode;
    int unsigned oready_mode;
    int unsigned lat_min, lat_max;
    bit          ctl_redir_req;
    logic [63:0] ctl_redir_addr;
    bit          redir_rand_en;
    bit          busy_en;
    bit          busy_fired;
    logic [63:0] busy_addr;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ {a[47:32], a[63:48]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, req, cyc);
        end
    endtask

    function automatic logic [63:0] acc_addr(input int unsigned i);
        if (i < acc_log.size()) return acc_log[i].addr;
        return 64'hDEAD_BEEF_DEAD_BEEF;
    endfunction
    function automatic int unsigned acc_cyc(input int unsigned i);
        if (i < acc_log.size()) return acc_log[i].cyc;
        return 32'h7FFF_0000;
    endfunction
    function automatic logic [63:0] pop_addr(input int unsigned i);
        if (i < pop_log.size()) return pop_log[i].addr;
        return 64'hDEAD_BEEF_DEAD_BEEF;
    endfunction
    function automatic int unsigned pop_cyc(input int unsigned i);
        if (i < pop_log.size()) return pop_log[i].cyc;
        return 32'h7FFF_1000;
    endfunction

    // Environment drive, per-cycle comparison and reference-model update.
    always @(negedge clk) begin : drive
        bit          r_rst, r_ready, r_rsp, r_oready, r_redir, exp_req, exp_out;
        logic [63:0] r_raddr;
        logic [31:0] r_data;
        int unsigned stale_n, due;
        infl_t       ti;
        exp_t        te;

        r_rst   = ctl_rst_n;
        r_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
        r_rsp   = 1'b0;
        r_data  = $urandom;
        if (r_rst && inflight.size() > 0 && inflight[0].due == cyc) begin
            r_rsp  = 1'b1;
            r_data = mem_word(inflight[0].addr);
        end
        case (oready_mode)
            0:       r_oready = 1'b0;
            1:       r_oready = 1'b1;
            default: r_oready = ($urandom_range(0, 3) != 0);
        endcase
        r_redir = 1'b0;
        r_raddr = {$urandom, $urandom};
        if (r_rst) begin
            if (ctl_redir_req) begin
                r_redir = 1'b1;
                r_raddr = ctl_redir_addr;
                ctl_redir_req = 1'b0;
                redir_cyc = cyc;
                acc_log.delete();
                pop_log.delete();
            end else if (busy_en && r_rsp && r_oready && exp_q.size() > 0 && exp_q[0].delivered) begin
                r_redir = 1'b1;
                r_raddr = busy_addr;
                busy_en = 1'b0;
                busy_fired = 1'b1;
                redir_cyc = cyc;
                acc_log.delete();
                pop_log.delete();
            end else if (redir_rand_en && $urandom_range(0, 99) < 4) begin
                r_redir = 1'b1;
            end
        end
        if (r_rst && !prev_rst) rel_cyc = cyc;
        prev_rst = r_rst;

        rst_n              = r_rst;
        bus.mem_req_ready  = r_ready;
        bus.mem_rsp_valid  = r_rsp;
        bus.mem_rsp_data   = r_data;
        bus.out_ready      = r_oready;
        bus.redirect_valid = r_redir;
        bus.redirect_addr  = r_raddr;
        #1;

        stale_n = 0;
        foreach (inflight[i]) if (inflight[i].stale) stale_n++;
        exp_req = r_rst && !r_redir && ((exp_q.size() + stale_n) < DEPTH);
        exp_out = r_rst && !r_redir && exp_q.size() > 0 && exp_q[0].delivered;

        check("req_valid", bus.mem_req_valid, exp_req);
        if (exp_req) check("req_addr", bus.mem_req_addr, next_addr);
        check("out_valid", bus.out_valid, exp_out);
        if (exp_out) begin
            check("out_pc", bus.out_pc, exp_q[0].pc);
            check("out_instr", bus.out_instr, mem_word(exp_q[0].pc));
        end

        last_req_valid = bus.mem_req_valid;
        if (r_redir && busy_fired && redir_cyc == cyc) busy_out_valid = bus.out_valid;
        if (bus.mem_req_valid && r_ready) acc_log.push_back('{bus.mem_req_addr, cyc});
        if (bus.out_valid && r_oready) pop_log.push_back('{bus.out_pc, cyc});

        if (!r_rst) begin
            inflight.delete();
            exp_q.delete();
            next_addr = RESET_PC;
            last_due  = 0;
        end else begin
            if (r_rsp) begin
                ti = inflight.pop_front();
                if (!ti.stale && !r_redir) begin
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (!exp_q[i].delivered) begin
                            te = exp_q[i];
                            te.delivered = 1'b1;
                            exp_q[i] = te;
                            break;
                        end
                    end
                end
            end
            if (exp_out && r_oready) void'(exp_q.pop_front());
            if (r_redir) begin
                exp_q.delete();
                for (int i = 0; i < inflight.size(); i++) begin
                    ti = inflight[i];
                    ti.stale = 1'b1;
                    inflight[i] = ti;
                end
                next_addr = r_raddr & ~64'h3;
            end
            if (exp_req && r_ready) begin
                due = cyc + $urandom_range(lat_min, lat_max);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                inflight.push_back('{next_addr, 1'b0, due});
                exp_q.push_back('{next_addr, 1'b0});
                next_addr = next_addr + 64'd4;
            end
        end
        cyc++;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic pulse_reset();
        ctl_rst_n = 1'b0;
        cycles(1);
        acc_log.delete();
        pop_log.delete();
        ctl_rst_n = 1'b1;
    endtask

    task automatic redirect(input logic [63:0] a);
        ctl_redir_addr = a;
        ctl_redir_req  = 1'b1;
    endtask

    initial begin
        ctl_rst_n = 1'b0; rst_n = 1'b0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
        bus.out_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_addr = '0;
        ready_mode = 0; oready_mode = 1; lat_min = 1; lat_max = 1;
        ctl_redir_req = 1'b0; ctl_redir_addr = '0; redir_rand_en = 1'b0;
        busy_en = 1'b0; busy_fired = 1'b0; busy_addr = '0; busy_out_valid = 1'b1;
        next_addr = RESET_PC; last_due = 0; last_req_valid = 1'b1;

        // Reset release, latency 1, consumer always ready.
        cycles(3);
        acc_log.delete(); pop_log.delete();
        ctl_rst_n = 1'b1;
        cycles(20);
        check("rst_acc0", acc_addr(0), 64'h1000);
        check("rst_acc1", acc_addr(1), 64'h1004);
        check("rst_acc2", acc_addr(2), 64'h1008);
        check("rst_first_issue", acc_cyc(0), rel_cyc);
        check("rst_pop0", pop_addr(0), 64'h1000);
        check("rst_pop1", pop_addr(1), 64'h1004);
        check("rst_out_latency", pop_cyc(0), acc_cyc(0) + 2);
        check("rst_out_rate", pop_cyc(1), pop_cyc(0) + 1);

        // Back-pressure: consumer stalled fills exactly DEPTH slots.
        oready_mode = 0;
        pulse_reset();
        cycles(15);
        check("bp_accepts", acc_log.size(), 4);
        check("bp_req_low", last_req_valid, 1'b0);
        oready_mode = 1;
        cycles(15);
        check("bp_pop0", pop_addr(0), 64'h1000);
        check("bp_pop1", pop_addr(1), 64'h1004);
        check("bp_pop2", pop_addr(2), 64'h1008);
        check("bp_pop3", pop_addr(3), 64'h100C);
        check("bp_resume_addr", acc_addr(4), 64'h1010);
        check("bp_resume_cyc", acc_cyc(4), pop_cyc(0) + 1);

        // Redirect with stale responses still in flight.
        lat_min = 3; lat_max = 3;
        pulse_reset();
        cycles(10);
        redirect(64'h2002);
        cycles(20);
        check("redir_addr", acc_addr(0), 64'h2000);
        check("redir_issue_cyc", acc_cyc(0), redir_cyc + 1);
        check("redir_first_out", pop_addr(0), 64'h2000);

        // Redirect coinciding with a response and a would-be pop.
        lat_min = 2; lat_max = 2;
        cycles(5);
        busy_addr = 64'h3000;
        busy_en = 1'b1;
        cycles(20);
        check("busy_fired", busy_fired, 1'b1);
        check("busy_no_handshake", busy_out_valid, 1'b0);
        check("busy_addr", acc_addr(0), 64'h3000);
        check("busy_first_out", pop_addr(0), 64'h3000);

        // 64-bit fetch address wrap.
        redirect(64'hFFFF_FFFF_FFFF_FFFC);
        cycles(12);
        check("wrap_acc0", acc_addr(0), 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_acc1", acc_addr(1), 64'h0);
        check("wrap_pop1", pop_addr(1), 64'h0);

        // Mid-stream reset with three requests outstanding.
        lat_min = 3; lat_max = 3;
        pulse_reset();
        cycles(3);
        check("mid_outstanding", inflight.size(), 3);
        pulse_reset();
        cycles(10);
        check("mid_acc0", acc_addr(0), 64'h1000);
        check("mid_issue_cyc", acc_cyc(0), rel_cyc);
        check("mid_pop0", pop_addr(0), 64'h1000);

        // Randomized traffic: memory stalls, variable latency, redirects.
        ready_mode = 1; oready_mode = 2; lat_min = 1; lat_max = 5;
        redir_rand_en = 1'b1;
        cycles(3000);
        redir_rand_en = 1'b0;
        cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
